midi_msg_parser: RTL and testbench

- Receive-side counterpart to the MIDI port transmit path.
- Consumes the byte stream from the port's UART receiver (rxdv/rxdata) and assembles complete MIDI messages: status plus 0–2 data bytes.
- Handles running status, interleaved real-time bytes and SysEx skipping.
- Presents each message on a single-entry valid/ready output register to the router core.

---
 rtl/midi_pkg.sv | 34 +++
 rtl/midi_msg_parser_if.sv | 21 ++
 rtl/midi_status_decode.sv | 47 ++++
 rtl/midi_msg_parser.sv | 176 +++++++++++++++++
 tb/tb_midi_msg_parser.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI constants and types for the receive parser and the status decoder.
package midi_pkg;

  localparam logic [7:0] STATUS_SYSEX_START = 8'hF0;
  localparam logic [7:0] STATUS_SYSEX_END   = 8'hF7;
  localparam logic [7:0] STATUS_TUNE_REQ    = 8'hF6;
  localparam logic [7:0] REALTIME_MIN       = 8'hF8;

  localparam logic [3:0] NOTE_OFF   = 4'h8;
  localparam logic [3:0] NOTE_ON    = 4'h9;
  localparam logic [3:0] PROG_CHG   = 4'hC;
  localparam logic [3:0] CHAN_PRESS = 4'hD;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_D1,
    ST_WAIT_D2,
    ST_SYSEX
  } parser_state_e;

  typedef logic [1:0] data_cnt_t;

  typedef enum logic [2:0] {
    CLS_DATA,
    CLS_REALTIME,
    CLS_SYSEX_START,
    CLS_SYSEX_END,
    CLS_CHANNEL,
    CLS_SYS_COMMON,
    CLS_TUNE_REQ,
    CLS_UNDEFINED
  } byte_class_e;

endpackage

// File: rtl/midi_msg_parser_if.sv
// Byte-in / message-out bundle between the UART receiver, the parser and the router core.
interface midi_msg_parser_if;
  logic       rxdv;
  logic [7:0] rxdata;
  logic       msg_valid;
  logic       msg_ready;
  logic [7:0] msg_status;
  logic [6:0] msg_data1;
  logic [6:0] msg_data2;
  logic [1:0] msg_len;

  modport master (
    output rxdv, rxdata, msg_ready,
    input  msg_valid, msg_status, msg_data1, msg_data2, msg_len
  );

  modport slave (
    input  rxdv, rxdata, msg_ready,
    output msg_valid, msg_status, msg_data1, msg_data2, msg_len
  );
endinterface

// File: rtl/midi_status_decode.sv
// Combinational MIDI byte classifier: class, expected data-byte count, running-status effect.
module midi_status_decode
  import midi_pkg::*;
(
  input  logic [7:0]  byte_i,
  output byte_class_e cls_o,
  output data_cnt_t   data_cnt_o,
  output logic        rs_set_o,
  output logic        rs_clear_o
);

  always_comb begin
    cls_o      = CLS_DATA;
    data_cnt_o = 2'd0;
    rs_set_o   = 1'b0;
    rs_clear_o = 1'b0;
    if (!byte_i[7]) begin
      cls_o = CLS_DATA;
    end else if (byte_i >= REALTIME_MIN) begin
      cls_o = CLS_REALTIME;
    end else if (byte_i == STATUS_SYSEX_START) begin
      cls_o      = CLS_SYSEX_START;
      rs_clear_o = 1'b1;
    end else if (byte_i == STATUS_SYSEX_END) begin
      cls_o = CLS_SYSEX_END;
    end else if (byte_i < STATUS_SYSEX_START) begin
      cls_o      = CLS_CHANNEL;
      rs_set_o   = 1'b1;
      data_cnt_o = (byte_i[7:4] == PROG_CHG || byte_i[7:4] == CHAN_PRESS) ? 2'd1 : 2'd2;
    end else begin
      rs_clear_o = 1'b1;
      unique case (byte_i)
        8'hF1, 8'hF3: begin
          cls_o      = CLS_SYS_COMMON;
          data_cnt_o = 2'd1;
        end
        8'hF2: begin
          cls_o      = CLS_SYS_COMMON;
          data_cnt_o = 2'd2;
        end
        STATUS_TUNE_REQ: cls_o = CLS_TUNE_REQ;
        default:         cls_o = CLS_UNDEFINED;
      endcase
    end
  end

endmodule

// File: rtl/midi_msg_parser.sv
// MIDI receive parser: assembles status + data bytes into messages on a one-entry output register.
// Optional macro MIDI_NOTE_OFF_NORMALIZE_EN: emit Note On velocity 0 as Note Off velocity 0x40.
module midi_msg_parser
  import midi_pkg::*;
#(
  parameter int unsigned DROP_CNT_WIDTH = 8,
  parameter int unsigned ERR_CNT_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  midi_msg_parser_if.slave          bus,
  output logic                      in_sysex,
  output logic [DROP_CNT_WIDTH-1:0] drop_count,
  output logic [ERR_CNT_WIDTH-1:0]  err_count
);

  parser_state_e state_q, state_d;
  logic [7:0]    status_q, status_d;
  logic          rs_valid_q, rs_valid_d;
  data_cnt_t     exp_q, exp_d;
  logic [6:0]    d1_q, d1_d;

  logic          out_valid_q;
  logic [7:0]    out_status_q;
  logic [6:0]    out_d1_q, out_d2_q;
  logic [1:0]    out_len_q;
  logic [DROP_CNT_WIDTH-1:0] drop_q;
  logic [ERR_CNT_WIDTH-1:0]  err_q;

  byte_class_e   cls;
  data_cnt_t     dec_cnt;
  logic          dec_rs_set, dec_rs_clear;

  logic          emit;
  logic [7:0]    em_status;
  logic [6:0]    em_d1, em_d2;
  logic [1:0]    em_len;
  logic          err_inc;

  midi_status_decode u_decode (
    .byte_i     (bus.rxdata),
    .cls_o      (cls),
    .data_cnt_o (dec_cnt),
    .rs_set_o   (dec_rs_set),
    .rs_clear_o (dec_rs_clear)
  );

  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    rs_valid_d = rs_valid_q;
    exp_d      = exp_q;
    d1_d       = d1_q;
    emit       = 1'b0;
    em_status  = '0;
    em_d1      = '0;
    em_d2      = '0;
    em_len     = '0;
    err_inc    = 1'b0;
    if (bus.rxdv) begin
      if (cls == CLS_DATA) begin
        unique case (state_q)
          ST_WAIT_D1: begin
            d1_d = bus.rxdata[6:0];
            if (exp_q == 2'd1) begin
              emit      = 1'b1;
              em_status = status_q;
              em_d1     = bus.rxdata[6:0];
              em_len    = 2'd2;
              state_d   = rs_valid_q ? ST_WAIT_D1 : ST_IDLE;
            end else begin
              state_d = ST_WAIT_D2;
            end
          end
          ST_WAIT_D2: begin
            emit      = 1'b1;
            em_status = status_q;
            em_d1     = d1_q;
            em_d2     = bus.rxdata[6:0];
            em_len    = 2'd3;
            state_d   = rs_valid_q ? ST_WAIT_D1 : ST_IDLE;
          end
          ST_IDLE:  err_inc = 1'b1;
          default:  ;
        endcase
      end else begin
        // Status bytes other than real-time and a stray F7 also end SysEx and drop partials.
        if (dec_rs_set)   rs_valid_d = 1'b1;
        if (dec_rs_clear) rs_valid_d = 1'b0;
        unique case (cls)
          CLS_REALTIME: begin
            emit      = 1'b1;
            em_status = bus.rxdata;
            em_len    = 2'd1;
          end
          CLS_SYSEX_START: begin
            status_d = '0;
            state_d  = ST_SYSEX;
          end
          CLS_SYSEX_END: begin
            if (state_q == ST_SYSEX) state_d = ST_IDLE;
          end
          CLS_CHANNEL, CLS_SYS_COMMON: begin
            status_d = bus.rxdata;
            exp_d    = dec_cnt;
            state_d  = ST_WAIT_D1;
          end
          CLS_TUNE_REQ: begin
            emit      = 1'b1;
            em_status = bus.rxdata;
            em_len    = 2'd1;
            status_d  = '0;
            state_d   = ST_IDLE;
          end
          default: begin
            status_d = '0;
            state_d  = ST_IDLE;
          end
        endcase
      end
    end
`ifdef MIDI_NOTE_OFF_NORMALIZE_EN
    if (emit && em_len == 2'd3 && em_status[7:4] == NOTE_ON && em_d2 == 7'd0) begin
      em_status = {NOTE_OFF, em_status[3:0]};
      em_d2     = 7'h40;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      status_q     <= '0;
      rs_valid_q   <= 1'b0;
      exp_q        <= '0;
      d1_q         <= '0;
      out_valid_q  <= 1'b0;
      out_status_q <= '0;
      out_d1_q     <= '0;
      out_d2_q     <= '0;
      out_len_q    <= '0;
      drop_q       <= '0;
      err_q        <= '0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      rs_valid_q <= rs_valid_d;
      exp_q      <= exp_d;
      d1_q       <= d1_d;
      if (emit) begin
        if (out_valid_q && !bus.msg_ready) begin
          if (drop_q != '1) drop_q <= drop_q + 1'b1;
        end else begin
          out_valid_q  <= 1'b1;
          out_status_q <= em_status;
          out_d1_q     <= em_d1;
          out_d2_q     <= em_d2;
          out_len_q    <= em_len;
        end
      end else if (out_valid_q && bus.msg_ready) begin
        out_valid_q <= 1'b0;
      end
      if (err_inc && err_q != '1) err_q <= err_q + 1'b1;
    end
  end

  assign bus.msg_valid  = out_valid_q;
  assign bus.msg_status = out_status_q;
  assign bus.msg_data1  = out_d1_q;
  assign bus.msg_data2  = out_d2_q;
  assign bus.msg_len    = out_len_q;
  assign in_sysex       = (state_q == ST_SYSEX);
  assign drop_count     = drop_q;
  assign err_count      = err_q;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Scoreboard bench for midi_msg_parser; honours MIDI_NOTE_OFF_NORMALIZE_EN for expected values.
module tb_midi_msg_parser;

  typedef struct {
    logic [7:0] st;
    logic [6:0] d1;
    logic [6:0] d2;
    logic [1:0] len;
  } msg_t;

  logic       clk;
  logic       rst;
  logic       in_sysex;
  logic [7:0] drop_count;
  logic [7:0] err_count;

  midi_msg_parser_if bus ();

  midi_msg_parser #(
    .DROP_CNT_WIDTH (8),
    .ERR_CNT_WIDTH  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .in_sysex   (in_sysex),
    .drop_count (drop_count),
    .err_count  (err_count)
  );

  msg_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic expect_msg(input logic [7:0] st, input logic [6:0] d1,
                            input logic [6:0] d2, input logic [1:0] len);
    msg_t m;
    m.st = st; m.d1 = d1; m.d2 = d2; m.len = len;
    sb.push_back(m);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rxdv   = 1'b1;
    bus.rxdata = b;
    @(negedge clk);
    bus.rxdv   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},  32'(bus.msg_valid), 0);
    check({tag, "_status"}, 32'(bus.msg_status), 0);
    check({tag, "_d1"},     32'(bus.msg_data1), 0);
    check({tag, "_d2"},     32'(bus.msg_data2), 0);
    check({tag, "_len"},    32'(bus.msg_len), 0);
    check({tag, "_sysex"},  32'(in_sysex), 0);
    check({tag, "_drop"},   32'(drop_count), 0);
    check({tag, "_err"},    32'(err_count), 0);
  endtask

  // Monitor: samples after inputs settle, pops on every accepted transfer.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst && bus.msg_valid && bus.msg_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_msg", 32'(sb.size()), 1);
        end else begin
          msg_t m;
          m = sb.pop_front();
          check("msg_status", 32'(bus.msg_status), 32'(m.st));
          check("msg_data1",  32'(bus.msg_data1),  32'(m.d1));
          check("msg_data2",  32'(bus.msg_data2),  32'(m.d2));
          check("msg_len",    32'(bus.msg_len),    32'(m.len));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    rst           = 1'b0;
    bus.rxdv      = 1'b0;
    bus.rxdata    = 8'h00;
    bus.msg_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // Note On, full three bytes; valid one cycle after the last strobe.
    expect_msg(8'h90, 7'h3C, 7'h64, 2'd3);
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
    check("t1_latency_valid", 32'(bus.msg_valid), 1);
    repeat (2) @(negedge clk);

    // Running status with a velocity-0 Note On.
    expect_msg(8'h90, 7'h3C, 7'h64, 2'd3);
`ifdef MIDI_NOTE_OFF_NORMALIZE_EN
    expect_msg(8'h80, 7'h40, 7'h40, 2'd3);
`else
    expect_msg(8'h90, 7'h40, 7'h00, 2'd3);
`endif
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
    send_byte(8'h40); send_byte(8'h00);
    repeat (2) @(negedge clk);

    // Real-time byte between status and data.
    expect_msg(8'hF8, 7'h00, 7'h00, 2'd1);
    expect_msg(8'hC5, 7'h07, 7'h00, 2'd2);
    send_byte(8'hC5); send_byte(8'hF8); send_byte(8'h07);
    repeat (2) @(negedge clk);

    // SysEx skipping; trailing data byte has no running status.
    expect_msg(8'hF8, 7'h00, 7'h00, 2'd1);
    send_byte(8'hF0);
    check("sysex_enter", 32'(in_sysex), 1);
    send_byte(8'h43); send_byte(8'h12); send_byte(8'hF8);
    check("sysex_hold", 32'(in_sysex), 1);
    check("sysex_err_quiet", 32'(err_count), 0);
    send_byte(8'hF7);
    check("sysex_exit", 32'(in_sysex), 0);
    send_byte(8'h3C);
    check("orphan_err", 32'(err_count), 1);
    repeat (2) @(negedge clk);

    // System common messages return to IDLE after completing.
    expect_msg(8'hF2, 7'h01, 7'h02, 2'd3);
    expect_msg(8'hF3, 7'h7F, 7'h00, 2'd2);
    expect_msg(8'hF6, 7'h00, 7'h00, 2'd1);
    send_byte(8'hF2); send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h05);
    check("syscommon_idle_err", 32'(err_count), 2);
    send_byte(8'hF3); send_byte(8'h7F);
    send_byte(8'hF6);
    repeat (2) @(negedge clk);

    // Back-pressure: first message held, second dropped.
    bus.msg_ready = 1'b0;
    expect_msg(8'hB0, 7'h07, 7'h7F, 2'd3);
    send_byte(8'hB0); send_byte(8'h07); send_byte(8'h7F);
    send_byte(8'hB0); send_byte(8'h07); send_byte(8'h00);
    check("hold_valid",  32'(bus.msg_valid), 1);
    check("hold_status", 32'(bus.msg_status), 32'h B0);
    check("hold_d1",     32'(bus.msg_data1), 32'h07);
    check("hold_d2",     32'(bus.msg_data2), 32'h7F);
    check("hold_len",    32'(bus.msg_len), 3);
    check("drop_count",  32'(drop_count), 1);
    bus.msg_ready = 1'b1;
    @(negedge clk); #2;
    check("valid_clears", 32'(bus.msg_valid), 0);

    // Reset mid-message discards the partial.
    send_byte(8'h90); send_byte(8'h3C);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    rst = 1'b1;
    send_byte(8'h64);
    check("post_reset_err", 32'(err_count), 1);
    @(negedge clk);
    check("post_reset_nomsg", 32'(bus.msg_valid), 0);

    // Error counter saturation.
    for (int unsigned i = 0; i < 300; i++) send_byte(8'h11);
    check("err_saturate", 32'(err_count), 255);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
